cache_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction-cache and data-cache miss paths of the pipelined datapath.
- Accepts whole-line read/write requests from each cache and arbitrates between them round-robin.
- Serialises each granted request into a fixed-length burst of beats on the memory side, then returns one-cycle completion to the granted cache.

---
 rtl/cache_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one burst-oriented memory port between the
// icache and dcache miss paths. A granted whole-line request is serialised into
// BURST_LEN beats, then completion is pulsed back to the granted cache for one cycle.
module cache_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_read,
  input  logic [ADDR_W-1:0]           i_addr,
  output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
  output logic                        i_resp,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [ADDR_W-1:0]           d_addr,
  input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
  output logic                        d_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_addr,
  output logic [BEAT_W-1:0]           pmem_wdata,
  input  logic [BEAT_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp
);

  localparam int unsigned LineW = BEAT_W * BURST_LEN;
  localparam int unsigned OffW  = $clog2(LineW / 8);
  localparam int unsigned CntW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0]   LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] AddrMask = {{(ADDR_W - OffW){1'b1}}, {OffW{1'b0}}};

  typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_q, beat_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_dc_q, last_dc_d;  // 1: dcache held the most recent grant
  logic              wr_q, wr_d;

  // State register; async reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      line_q    <= '0;
      addr_q    <= '0;
      last_dc_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      last_dc_q <= last_dc_d;
      wr_q      <= wr_d;
    end
  end

  // Next-state: arbitration in idle, beat sequencing during bursts.
  always_comb begin
    logic d_pend;
    logic grant_dc;
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    addr_d    = addr_q;
    last_dc_d = last_dc_q;
    wr_d      = wr_q;
    d_pend    = d_read | d_write;
    grant_dc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_read || d_pend) begin
          // On a tie, the side that did not win last time gets the port.
          grant_dc  = d_pend && (!i_read || !last_dc_q);
          last_dc_d = grant_dc;
          wr_d      = grant_dc && d_write;
          addr_d    = (grant_dc ? d_addr : i_addr) & AddrMask;
          beat_d    = '0;
          if (grant_dc && d_write) begin
            line_d  = d_wdata;
            state_d = StDWr;
          end else begin
            state_d = grant_dc ? StDRd : StIRd;
          end
        end
      end
      StIRd, StDRd, StDWr: begin
        if (pmem_resp) begin
          if (state_q != StDWr) begin
            line_d[32'(beat_q) * BEAT_W +: BEAT_W] = pmem_rdata;
          end
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StDone;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    logic busy;
    busy       = (state_q == StIRd) || (state_q == StDRd) || (state_q == StDWr);
    pmem_read  = (state_q == StIRd) || (state_q == StDRd);
    pmem_write = (state_q == StDWr);
    pmem_addr  = busy ? addr_q : '0;
    pmem_wdata = (state_q == StDWr) ? line_q[32'(beat_q) * BEAT_W +: BEAT_W] : '0;
    i_resp     = (state_q == StDone) && !last_dc_q;
    d_resp     = (state_q == StDone) && last_dc_q;
    i_rdata    = i_resp ? line_q : '0;
    d_rdata    = (d_resp && !wr_q) ? line_q : '0;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked each cycle against a
// transaction-level model of the arbiter.
module tb_cache_arbiter;

  localparam int ADDR_W    = 32;
  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int LINE_W    = BEAT_W * BURST_LEN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  cache_arbiter #(
    .ADDR_W    (ADDR_W),
    .BEAT_W    (BEAT_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit              m_busy = 0, m_done = 0, m_side_d = 0, m_wr = 0, m_last_d = 0;
  int              m_n = 0;
  logic [31:0]     m_addr = '0;
  logic [255:0]    m_wline = '0;
  logic [63:0]     m_beats[$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_done = 0; m_side_d = 0; m_wr = 0; m_last_d = 0; m_n = 0;
      m_beats.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        if (!m_wr) m_beats.push_back(pmem_rdata);
        m_n++;
        if (m_n == BURST_LEN) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (i_read || d_read || d_write) begin
      m_side_d = (d_read || d_write) && (!i_read || !m_last_d);
      m_last_d = m_side_d;
      m_wr     = m_side_d && d_write;
      m_addr   = (m_side_d ? d_addr : i_addr) & 32'hFFFF_FFE0;
      m_wline  = d_wdata;
      m_beats.delete();
      m_n      = 0;
      m_busy   = 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [255:0] line;
    @(negedge clk);
    line = '0;
    foreach (m_beats[k]) line[k*64 +: 64] = m_beats[k];
    chk("m_pmem_read", 256'(pmem_read), 256'(m_busy && !m_wr));
    chk("m_pmem_write", 256'(pmem_write), 256'(m_busy && m_wr));
    chk("m_pmem_addr", 256'(pmem_addr), 256'(m_busy ? m_addr : 32'h0));
    chk("m_pmem_wdata", 256'(pmem_wdata),
        256'((m_busy && m_wr) ? m_wline[m_n*64 +: 64] : 64'h0));
    chk("m_i_resp", 256'(i_resp), 256'(m_done && !m_side_d));
    chk("m_d_resp", 256'(d_resp), 256'(m_done && m_side_d));
    chk("m_i_rdata", i_rdata, (m_done && !m_side_d) ? line : 256'h0);
    chk("m_d_rdata", d_rdata, (m_done && m_side_d && !m_wr) ? line : 256'h0);
  end

  // ---------------- memory responder ----------------
  // Mode 0: zero-wait; 1: three stall cycles before each strobe; 2: random.
  int mem_mode = 0, mem_cnt = 0, stall = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mem_cnt = 0; stall = 0; pmem_resp = 1'b0;
    end else begin
      case (mem_mode)
        0: pmem_resp = pmem_read | pmem_write;
        1: begin
          if (pmem_read | pmem_write) begin
            if (stall == 3) begin pmem_resp = 1'b1; stall = 0; end
            else begin pmem_resp = 1'b0; stall++; end
          end else begin
            pmem_resp = 1'b0; stall = 0;
          end
        end
        default: pmem_resp = ($urandom_range(9) < 6);
      endcase
    end
    if (mem_mode == 2) begin
      pmem_rdata = {$urandom, $urandom};
    end else begin
      pmem_rdata = 64'h1111_1111_1111_1111 * 64'(mem_cnt % 4 + 1);
      if (pmem_resp && pmem_read) mem_cnt++;
    end
  end

  localparam logic [255:0] PatLine = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  task automatic chk_zero(input string tag);
    chk({tag, "_pmem_read"}, 256'(pmem_read), 256'(0));
    chk({tag, "_pmem_write"}, 256'(pmem_write), 256'(0));
    chk({tag, "_pmem_addr"}, 256'(pmem_addr), 256'(0));
    chk({tag, "_pmem_wdata"}, 256'(pmem_wdata), 256'(0));
    chk({tag, "_i_resp"}, 256'(i_resp), 256'(0));
    chk({tag, "_d_resp"}, 256'(d_resp), 256'(0));
    chk({tag, "_i_rdata"}, i_rdata, 256'(0));
    chk({tag, "_d_rdata"}, d_rdata, 256'(0));
  endtask

  // Icache read with zero-wait memory; called just after a falling edge.
  task automatic run_iread(input logic [31:0] a, input logic [31:0] ea, input string tag);
    logic [7:0] rm, rp;
    logic       dside;
    rm = '0; rp = '0; dside = 1'b0;
    i_read = 1'b1;
    i_addr = a;
    for (int k = 0; k < 8; k++) begin
      tick();
      rm[k] = pmem_read;
      rp[k] = i_resp;
      if (pmem_write || d_resp) dside = 1'b1;
      if (k == 0) chk({tag, "_addr"}, 256'(pmem_addr), 256'(ea));
      if (k == 1) i_addr = 32'hDEAD_BEEF;
      if (i_resp) begin
        chk({tag, "_rdata"}, i_rdata, PatLine);
        i_read = 1'b0;
      end
    end
    chk({tag, "_read_cycles"}, 256'(rm), 256'(8'b0000_1111));
    chk({tag, "_resp_cycle"}, 256'(rp), 256'(8'b0001_0000));
    chk({tag, "_no_dside"}, 256'(dside), 256'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0]   ordv;
    int           n, nb, nr, nw, rc, ns, nresp;
    logic         rd, got, bad_addr, prev_strobe;
    logic [63:0]  wexp[4];
    wexp = '{64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908,
             64'h1716_1514_1312_1110, 64'h1F1E_1D1C_1B1A_1918};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // Single icache read.
    run_iread(32'h0000_1234, 32'h0000_1220, "t1");

    // Tie right after reset: D first, then alternating.
    do_reset();
    i_read = 1'b1; d_read = 1'b1; n = 0; ordv = '0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      tick();
      if (i_resp) begin ordv[n] = 1'b0; n++; i_read = 1'b0; end
      else i_read = 1'b1;
      if (d_resp) begin ordv[n] = 1'b1; n++; d_read = 1'b0; end
      else d_read = 1'b1;
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("t2_count", 256'(n), 256'(4));
    chk("t2_order", 256'(ordv), 256'(4'b0101));

    // Dcache write-back of bytes 0x00..0x1F.
    d_write = 1'b1; d_addr = 32'h8000_0040;
    for (int b = 0; b < 32; b++) d_wdata[8*b +: 8] = 8'(b);
    nb = 0; nr = 0; rd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pmem_write) begin
        if (nb < 4) chk("t3_wdata", 256'(pmem_wdata), 256'(wexp[nb]));
        chk("t3_addr", 256'(pmem_addr), 256'(32'h8000_0040));
        nb++;
        d_wdata = '1;
      end
      if (pmem_read) rd = 1'b1;
      if (d_resp) begin
        nr++;
        chk("t3_d_rdata", d_rdata, 256'(0));
        d_write = 1'b0;
      end
    end
    chk("t3_beats", 256'(nb), 256'(4));
    chk("t3_no_read", 256'(rd), 256'(0));
    chk("t3_one_resp", 256'(nr), 256'(1));

    // Read and write together: write wins.
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0ABC;
    for (int w = 0; w < 8; w++) d_wdata[32*w +: 32] = $urandom;
    nw = 0; nr = 0; rd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pmem_write) begin
        if (nw == 0) chk("t5_addr", 256'(pmem_addr), 256'(32'h0000_0AA0));
        nw++;
      end
      if (pmem_read) rd = 1'b1;
      if (d_resp) begin nr++; d_read = 1'b0; d_write = 1'b0; end
    end
    chk("t5_write_beats", 256'(nw), 256'(4));
    chk("t5_no_read", 256'(rd), 256'(0));
    chk("t5_one_resp", 256'(nr), 256'(1));

    // Stalled memory: three idle cycles before each strobe.
    mem_mode = 1;
    i_read = 1'b1; i_addr = 32'h2000_011F;
    rc = 0; ns = 0; nr = 0; got = 1'b0; bad_addr = 1'b0; prev_strobe = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pmem_read) begin
        rc++;
        if (pmem_addr !== 32'h2000_0100) bad_addr = 1'b1;
        if (pmem_resp) ns++;
      end
      if (i_resp) begin
        nr++;
        got = 1'b1;
        chk("t4_strobes_before_resp", 256'(ns), 256'(4));
        chk("t4_resp_after_strobe", 256'(prev_strobe), 256'(1));
        chk("t4_rdata", i_rdata, PatLine);
        i_read = 1'b0;
      end
      prev_strobe = pmem_resp && pmem_read;
    end
    mem_mode = 0;
    chk("t4_got_resp", 256'(got), 256'(1));
    chk("t4_one_resp", 256'(nr), 256'(1));
    chk("t4_read_held", 256'(rc), 256'(16));
    chk("t4_addr_stable", 256'(bad_addr), 256'(0));

    // Asynchronous reset after two beats of a read.
    i_read = 1'b1; i_addr = 32'h0000_5555;
    tick();
    tick();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_zero("t6_abort");
    i_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_hold_resp", 256'({i_resp, d_resp, pmem_read}), 256'(0));
    end
    rst = 1'b1;
    run_iread(32'h0000_3008, 32'h0000_3000, "t6_after");

    // Randomized traffic, checked by the model every cycle.
    mem_mode = 2; nresp = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (i_resp) begin nresp++; i_read = 1'b0; end
      else if (!i_read && $urandom_range(3) == 0) i_read = 1'b1;
      i_addr = $urandom;
      if (d_resp) begin nresp++; d_read = 1'b0; d_write = 1'b0; end
      else if (!d_read && !d_write && $urandom_range(3) == 0) begin
        logic [1:0] s;
        s = 2'($urandom_range(1, 3));
        d_read = s[0]; d_write = s[1];
      end
      d_addr = $urandom;
      for (int w = 0; w < 8; w++) d_wdata[32*w +: 32] = $urandom;
    end
    chk("rnd_enough_resps", 256'(nresp > 50), 256'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
